// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM peripheral: command byte layout, default
// widths and decoder state encoding.
package pwm_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 6;
  localparam int unsigned DATA_W_DEFAULT = 8;

  // Command byte fields
  localparam int unsigned CMD_RW_BIT = 7;
  localparam int unsigned CMD_HL_BIT = 6;

  // Decoder states
  localparam logic [0:0] S_CMD  = 1'b0;
  localparam logic [0:0] S_DATA = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronised).
// RST_VAL sets the value both flops take in reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/instr_decode.sv
// Decodes two-byte SPI frames from the bridge into single-cycle register
// read/write strobes and returns read data to the bridge.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   cs_n                    raw SPI chip select (async), frame realignment only
//   byte_sync, data_in      new-byte pulse and byte from the bridge
//   data_out                last read result, shifted out in the next frame
//   read, write             one-cycle strobes to the register file
//   addr, hi_sel            register address and byte-lane select
//   data_read               register file read data, valid while read = 1
//   data_write              write data, held from the write strobe onward
module instr_decode
  import pwm_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              byte_sync,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic              hi_sel,
  input  logic [DATA_W-1:0] data_read,
  output logic [DATA_W-1:0] data_write
);

  logic              cs_s;
  logic [0:0]        state, state_nxt;
  logic              rw_q, rw_nxt;
  logic              read_nxt, write_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              hi_sel_nxt;
  logic [DATA_W-1:0] data_write_nxt;
  logic [DATA_W-1:0] data_out_nxt;

  // Chip select resynchronised to clk; idle (high) out of reset
  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cs_n),
    .q     (cs_s)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_CMD;
      rw_q       <= 1'b0;
      read       <= 1'b0;
      write      <= 1'b0;
      addr       <= '0;
      hi_sel     <= 1'b0;
      data_write <= '0;
      data_out   <= '0;
    end else begin
      state      <= state_nxt;
      rw_q       <= rw_nxt;
      read       <= read_nxt;
      write      <= write_nxt;
      addr       <= addr_nxt;
      hi_sel     <= hi_sel_nxt;
      data_write <= data_write_nxt;
      data_out   <= data_out_nxt;
    end
  end

  // Next-state and strobe decode; idle chip select overrides any byte
  always_comb begin
    state_nxt      = state;
    rw_nxt         = rw_q;
    read_nxt       = 1'b0;
    write_nxt      = 1'b0;
    addr_nxt       = addr;
    hi_sel_nxt     = hi_sel;
    data_write_nxt = data_write;
    // Capture read data during the read strobe cycle only
    data_out_nxt   = read ? data_read : data_out;

    if (cs_s) begin
      state_nxt = S_CMD;
    end else if (byte_sync) begin
      case (state)
        S_CMD: begin
          rw_nxt     = data_in[CMD_RW_BIT];
          hi_sel_nxt = data_in[CMD_HL_BIT];
          addr_nxt   = data_in[ADDR_W-1:0];
          // Reads fire off the command byte; the data byte is a dummy
          read_nxt   = ~data_in[CMD_RW_BIT];
          state_nxt  = S_DATA;
        end
        S_DATA: begin
          state_nxt = S_CMD;
          if (rw_q) begin
            write_nxt      = 1'b1;
            data_write_nxt = data_in;
          end
        end
        default: state_nxt = S_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_decode.sv
module tb_instr_decode;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       byte_sync = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic       hi_sel;
  logic [7:0] data_read;
  logic [7:0] data_write;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    bit         w;
    logic [5:0] addr;
    logic       hi;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  instr_decode dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_n       (cs_n),
    .byte_sync  (byte_sync),
    .data_in    (data_in),
    .data_out   (data_out),
    .read       (read),
    .write      (write),
    .addr       (addr),
    .hi_sel     (hi_sel),
    .data_read  (data_read),
    .data_write (data_write)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: per-address value, 0xFF outside the read strobe
  assign data_read = read ? (8'h59 ^ {2'b00, addr}) : 8'hFF;

  // Scoreboard: every strobe pops one expectation and is compared against it
  always @(negedge clk) begin
    if (rst_n && (read || write)) begin
      tests++;
      if (read && write) begin
        fails++;
        $display("FAIL strobe_overlap: read=%b write=%b at cycle %0d, required never both", read, write, cyc);
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe: read=%b write=%b addr=%h at cycle %0d, required none", read, write, addr, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (write !== mon_e.w || read !== !mon_e.w || addr !== mon_e.addr || hi_sel !== mon_e.hi ||
            cyc != mon_e.cyc || (mon_e.w && data_write !== mon_e.data)) begin
          fails++;
          $display("FAIL strobe: got w=%b r=%b addr=%h hi=%b data=%h cyc=%0d, required w=%b addr=%h hi=%b data=%h cyc=%0d",
                   write, read, addr, hi_sel, data_write, cyc,
                   mon_e.w, mon_e.addr, mon_e.hi, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic exp_t mk(input bit w, input logic [5:0] a, input logic hi, input logic [7:0] d);
    exp_t e;
    e.w = w; e.addr = a; e.hi = hi; e.data = d; e.cyc = 0;
    return e;
  endfunction

  // Drive one byte for one cycle; queue the expected strobe for the next cycle
  task automatic send_byte(input logic [7:0] b, input bit has_exp, input exp_t e);
    exp_t ee;
    @(negedge clk);
    data_in   = b;
    byte_sync = 1'b1;
    if (has_exp) begin
      ee = e;
      ee.cyc = cyc + 1;
      exp_q.push_back(ee);
    end
    @(negedge clk);
    byte_sync = 1'b0;
    data_in   = 8'h00;
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (read !== 1'b0 || write !== 1'b0) begin
      fails++; $display("FAIL reset_strobes: read=%b write=%b, required 0 0", read, write);
    end
    tests++;
    if (addr !== 6'h00 || hi_sel !== 1'b0) begin
      fails++; $display("FAIL reset_addr: addr=%h hi_sel=%b, required 00 0", addr, hi_sel);
    end
    tests++;
    if (data_out !== 8'h00 || data_write !== 8'h00) begin
      fails++; $display("FAIL reset_data: data_out=%h data_write=%h, required 00 00", data_out, data_write);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read();
    cs_low();
    send_byte(8'h03, 1'b1, mk(1'b0, 6'h03, 1'b0, 8'h00));
    tests++;
    if (data_out !== 8'h00) begin
      fails++; $display("FAIL read_data_early: data_out=%h, required 00 during strobe cycle", data_out);
    end
    @(negedge clk);
    tests++;
    if (data_out !== 8'h5A) begin
      fails++; $display("FAIL read_data: data_out=%h, required 5a", data_out);
    end
    send_byte(8'h00, 1'b0, mk(1'b0, 6'h00, 1'b0, 8'h00));
    repeat (3) @(negedge clk);
    tests++;
    if (data_out !== 8'h5A) begin
      fails++; $display("FAIL read_data_hold: data_out=%h, required 5a", data_out);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL read_missing: %0d strobes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    cs_high();
  endtask

  task automatic test_write();
    cs_low();
    send_byte(8'hC5, 1'b0, mk(1'b0, 6'h00, 1'b0, 8'h00));
    send_byte(8'hA7, 1'b1, mk(1'b1, 6'h05, 1'b1, 8'hA7));
    repeat (3) @(negedge clk);
    tests++;
    if (data_write !== 8'hA7 || addr !== 6'h05 || hi_sel !== 1'b1) begin
      fails++; $display("FAIL write_hold: data_write=%h addr=%h hi=%b, required a7 05 1", data_write, addr, hi_sel);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL write_missing: %0d strobes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    cs_high();
  endtask

  task automatic test_abort();
    cs_low();
    send_byte(8'h81, 1'b0, mk(1'b0, 6'h00, 1'b0, 8'h00));
    cs_high();
    repeat (2) @(negedge clk);
    cs_low();
    send_byte(8'h82, 1'b0, mk(1'b0, 6'h00, 1'b0, 8'h00));
    send_byte(8'h11, 1'b1, mk(1'b1, 6'h02, 1'b0, 8'h11));
    repeat (2) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL abort_missing: %0d strobes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    cs_high();
  endtask

  task automatic test_back_to_back();
    cs_low();
    send_byte(8'h81, 1'b0, mk(1'b0, 6'h00, 1'b0, 8'h00));
    send_byte(8'h10, 1'b1, mk(1'b1, 6'h01, 1'b0, 8'h10));
    send_byte(8'h02, 1'b1, mk(1'b0, 6'h02, 1'b0, 8'h00));
    send_byte(8'hFF, 1'b0, mk(1'b0, 6'h00, 1'b0, 8'h00));
    repeat (2) @(negedge clk);
    tests++;
    if (data_out !== 8'h5B) begin
      fails++; $display("FAIL b2b_read_data: data_out=%h, required 5b", data_out);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL b2b_missing: %0d strobes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    cs_high();
  endtask

  // Byte arrives in the first cycle the synchronised chip select reads idle
  task automatic test_cs_collision();
    cs_low();
    @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    data_in   = 8'h03;
    byte_sync = 1'b1;
    @(negedge clk);
    byte_sync = 1'b0;
    data_in   = 8'h00;
    repeat (2) @(negedge clk);
    tests++;
    if (addr !== 6'h02 || hi_sel !== 1'b0) begin
      fails++; $display("FAIL collision_addr: addr=%h hi=%b, required 02 0", addr, hi_sel);
    end
    tests++;
    if (data_out !== 8'h5B) begin
      fails++; $display("FAIL collision_data_out: data_out=%h, required 5b", data_out);
    end
  endtask

  task automatic test_async_reset();
    cs_low();
    send_byte(8'h85, 1'b0, mk(1'b0, 6'h00, 1'b0, 8'h00));
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (addr !== 6'h00 || hi_sel !== 1'b0 || read !== 1'b0 || write !== 1'b0) begin
      fails++; $display("FAIL async_reset_ctrl: addr=%h hi=%b read=%b write=%b, required 00 0 0 0", addr, hi_sel, read, write);
    end
    tests++;
    if (data_out !== 8'h00 || data_write !== 8'h00) begin
      fails++; $display("FAIL async_reset_data: data_out=%h data_write=%h, required 00 00", data_out, data_write);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'h84, 1'b0, mk(1'b0, 6'h00, 1'b0, 8'h00));
    send_byte(8'h22, 1'b1, mk(1'b1, 6'h04, 1'b0, 8'h22));
    repeat (2) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL post_reset_missing: %0d strobes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    tests++;
    if (data_write !== 8'h22 || addr !== 6'h04) begin
      fails++; $display("FAIL post_reset_write: data_write=%h addr=%h, required 22 04", data_write, addr);
    end
    cs_high();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_abort();
    test_back_to_back();
    test_cs_collision();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
